// File: rtl/imgproc_pkg.sv
// Shared types for the 3x3 window image filter: filter mode and frame FSM state.
package imgproc_pkg;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {MODE_PASS, MODE_GAUSS, MODE_MAX, MODE_MIN} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH, ST_DONE} state_e;
endpackage

// File: rtl/imgproc_linebuf.sv
// DEPTH-deep shift buffer: dout is the value pushed DEPTH enables ago.
module imgproc_linebuf #(
  parameter int DEPTH = 128,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DEPTH-1:0][DW-1:0] mem;

  always_ff @(posedge clk)
    if (en) mem <= {mem[DEPTH-2:0], din};

  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/imgproc_win3.sv
// Streams an IMG_W x IMG_H frame, applies a mode-selected 3x3 filter, writes one result per pixel.
// Optional IMGPROC_THRESH_EN adds a thresh port and a binarising output stage (latency 3 instead of 2).
module imgproc_win3
  import imgproc_pkg::*;
#(
  parameter  int IMG_W = 128,
  parameter  int IMG_H = 128,
  parameter  int DW    = DW_DEF,
  localparam int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] orig_data,
  input  logic          orig_ready,
`ifdef IMGPROC_THRESH_EN
  input  logic [DW-1:0] thresh,
`endif
  output logic          request,
  output logic [AW-1:0] orig_addr,
  output logic          imgproc_ready,
  output logic [AW-1:0] imgproc_addr,
  output logic [DW-1:0] imgproc_data,
  output logic          finish
);
  localparam int N  = IMG_W*IMG_H;
  localparam int FW = $clog2(IMG_W+2);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DW+4;
`ifdef IMGPROC_THRESH_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  state_e state, state_nx;
  mode_e  mode_q;
  logic [AW-1:0] k, c_addr, s1_addr;
  logic [FW-1:0] fill, flush_cnt;
  logic [CW-1:0] c_col;
  logic [RW-1:0] c_row;
  logic          accept, inject, push, c_vld, s1_border, last_out;
  logic [DW-1:0] pix, filt;
  logic [STAGES:1] vld_pipe;
  logic [1:0][DW-1:0] lb_out;
  logic [2:0][DW-1:0] col_new;
  logic [2:0][2:0][DW-1:0] w;
  logic [GW-1:0] gsum;
  logic [DW-1:0] vmax, vmin;

  assign accept   = (state == ST_FETCH) && orig_ready;
  assign inject   = (state == ST_FLUSH) && (flush_cnt != FW'(IMG_W+1));
  assign push     = accept || inject;
  assign pix      = accept ? orig_data : '0;
  // A centre exists once the window has swallowed IMG_W+1 pixels
  assign c_vld    = push && (fill == FW'(IMG_W+1));
  assign request  = (state == ST_FETCH);
  assign finish   = (state == ST_DONE);
  assign orig_addr = k;
  assign imgproc_ready = vld_pipe[STAGES];
  assign last_out = imgproc_ready && (imgproc_addr == AW'(N-1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = ST_FETCH;
      ST_FETCH: if (accept && k == AW'(N-1)) state_nx = ST_FLUSH;
      ST_FLUSH: if (last_out) state_nx = ST_DONE;
      default:  state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q    <= MODE_PASS;
      k         <= '0;
      fill      <= '0;
      flush_cnt <= '0;
      c_addr    <= '0;
      c_col     <= '0;
      c_row     <= '0;
      s1_addr   <= '0;
      s1_border <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      if (state == ST_IDLE) mode_q <= mode_e'(mode);
      if (accept && k != AW'(N-1)) k <= k + 1'b1;
      if (inject) flush_cnt <= flush_cnt + 1'b1;
      if (push && !c_vld) fill <= fill + 1'b1;
      if (c_vld) begin
        s1_addr   <= c_addr;
        s1_border <= (c_row == '0) || (c_row == RW'(IMG_H-1)) ||
                     (c_col == '0) || (c_col == CW'(IMG_W-1));
        c_addr    <= c_addr + 1'b1;
        if (c_col == CW'(IMG_W-1)) begin
          c_col <= '0;
          c_row <= c_row + 1'b1;
        end else begin
          c_col <= c_col + 1'b1;
        end
      end
      vld_pipe <= {vld_pipe[STAGES-1:1], c_vld};
    end

  // Row 0 of the window is the oldest line, column 2 the newest pixel
  assign col_new = {pix, lb_out[0], lb_out[1]};

  imgproc_linebuf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk(clk), .en(push), .din(pix), .dout(lb_out[0]));
  imgproc_linebuf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .en(push), .din(lb_out[0]), .dout(lb_out[1]));

  always_ff @(posedge clk)
    if (push)
      for (int r = 0; r < 3; r++) w[r] <= {col_new[r], w[r][2:1]};

  always_comb begin
    gsum = '0;
    vmax = w[0][0];
    vmin = w[0][0];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gsum = gsum + (GW'(w[r][c]) << (int'(r == 1) + int'(c == 1)));
        if (w[r][c] > vmax) vmax = w[r][c];
        if (w[r][c] < vmin) vmin = w[r][c];
      end
    filt = w[1][1];
    case (mode_q)
      MODE_GAUSS: filt = DW'(gsum >> 4);
      MODE_MAX:   filt = vmax;
      MODE_MIN:   filt = vmin;
      default:    filt = w[1][1];
    endcase
  end

`ifdef IMGPROC_THRESH_EN
  logic [DW-1:0] d2;
  logic [AW-1:0] a2;
  logic          b2;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d2 <= '0;
      a2 <= '0;
      b2 <= 1'b0;
      imgproc_addr <= '0;
      imgproc_data <= '0;
    end else begin
      if (vld_pipe[1]) begin
        d2 <= filt;
        a2 <= s1_addr;
        b2 <= s1_border;
      end
      if (vld_pipe[2]) begin
        imgproc_addr <= a2;
        imgproc_data <= (!b2 && d2 >= thresh) ? '1 : '0;
      end
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      imgproc_addr <= '0;
      imgproc_data <= '0;
    end else if (vld_pipe[1]) begin
      imgproc_addr <= s1_addr;
      imgproc_data <= s1_border ? '0 : filt;
    end
`endif
endmodule

// File: tb/tb_imgproc_win3.sv
// Randomised frame-level bench for imgproc_win3 on a 16x8 image against a direct 2D reference.
module tb_imgproc_win3;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int N  = W*H;
  localparam int AW = $clog2(N);
`ifdef IMGPROC_THRESH_EN
  localparam int LAT = 3;
  logic [7:0] thresh = 8'd64;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [7:0]    orig_data;
  logic          orig_ready;
  logic          request;
  logic [AW-1:0] orig_addr;
  logic          imgproc_ready;
  logic [AW-1:0] imgproc_addr;
  logic [7:0]    imgproc_data;
  logic          finish;

  logic [7:0] img     [N];
  logic [7:0] got     [N];
  logic [7:0] ref_got [N];
  int         acc_cyc [N];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, exp_addr, nstr, nacc, cur_mode;
  bit stall_en = 0, mon_en = 0, fin_due = 0;

  imgproc_win3 #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .orig_data(orig_data), .orig_ready(orig_ready),
`ifdef IMGPROC_THRESH_EN
    .thresh(thresh),
`endif
    .request(request), .orig_addr(orig_addr), .imgproc_ready(imgproc_ready),
    .imgproc_addr(imgproc_addr), .imgproc_data(imgproc_data), .finish(finish));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign orig_data = img[orig_addr];

  initial begin
    orig_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 orig_ready = stall_en ? ($urandom_range(1) == 1) : 1'b1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int tx(input int v);
`ifdef IMGPROC_THRESH_EN
    return (v >= int'(thresh)) ? 255 : 0;
`else
    return v;
`endif
  endfunction

  function automatic int ref_pix(input int a);
    int r, c, acc, mx, mn, p, v;
    r = a / W; c = a % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    acc = 0; mx = 0; mn = 255;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        p = int'(img[(r+dr)*W + c + dc]);
        acc += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * p;
        if (p > mx) mx = p;
        if (p < mn) mn = p;
      end
    case (cur_mode)
      1: v = acc / 16;
      2: v = mx;
      3: v = mn;
      default: v = int'(img[a]);
    endcase
    return tx(v);
  endfunction

  always @(negedge clk) if (mon_en) begin
    int a;
    if (fin_due) begin
      chk("finish_after_last", finish, 1);
      fin_due = 0;
    end
    if (request && orig_ready) begin
      acc_cyc[orig_addr] = cyc;
      nacc++;
    end
    if (imgproc_ready) begin
      a = int'(imgproc_addr);
      chk($sformatf("addr_order#%0d", nstr), a, exp_addr);
      chk($sformatf("data@%0d", a), imgproc_data, ref_pix(a));
      if (a + W + 1 < N) chk($sformatf("latency@%0d", a), cyc - acc_cyc[a+W+1], LAT);
      got[a] = imgproc_data;
      if (a == N-1) begin
        chk("finish_not_early", finish, 0);
        fin_due = 1;
      end
      exp_addr++;
      nstr++;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_request"}, request, 0);
    chk({tag, "_orig_addr"}, orig_addr, 0);
    chk({tag, "_ready"}, imgproc_ready, 0);
    chk({tag, "_addr"}, imgproc_addr, 0);
    chk({tag, "_data"}, imgproc_data, 0);
    chk({tag, "_finish"}, finish, 0);
  endtask

  task automatic run_frame(input int m, input bit stall, input int abort_at);
    bit done;
    @(negedge clk);
    rst_n = 1'b0;
    mon_en = 0;
    #2 chk_reset("rst");
    mode = 2'(m); cur_mode = m; stall_en = stall;
    exp_addr = 0; nstr = 0; nacc = 0; fin_due = 0;
    @(negedge clk);
    mon_en = 1;
    rst_n = 1'b1;
    done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      #1;
      if (t == 0) begin
        chk("start_addr", orig_addr, 0);
        chk("start_request", request, 1);
      end
      if (t == 4) mode = 2'(m ^ 3);
      if (abort_at >= 0 && nacc >= abort_at) begin
        rst_n = 1'b0;
        mon_en = 0;
        #1 chk_reset("abort");
        return;
      end
      if (finish) done = 1;
    end
    chk("frame_done", done, 1);
    chk("strobe_count", nstr, N);
    repeat (3) @(negedge clk);
    #1;
    chk("done_finish_held", finish, 1);
    chk("done_request", request, 0);
    chk("done_ready", imgproc_ready, 0);
    mon_en = 0;
  endtask

  initial begin
    int diffs;
    rst_n = 1'b0;
    mode  = 2'd0;
    #12;
    chk_reset("por");

    foreach (img[i]) img[i] = 8'd100;
    run_frame(1, 0, -1);
    chk("t1_interior", got[W+1], tx(100));
    chk("t1_border", got[0], 0);
    chk("t1_last", got[N-1], 0);

    foreach (img[i]) img[i] = 8'd0;
    img[3*W+5] = 8'd255;
    run_frame(1, 0, -1);
    chk("t2_centre", got[3*W+5], tx(63));
    chk("t2_edge", got[3*W+4], tx(31));
    chk("t2_diag", got[2*W+6], tx(15));
    chk("t2_far", got[5*W+9], 0);
    run_frame(2, 0, -1);
    chk("t2_max_corner", got[2*W+4], tx(255));
    chk("t2_max_corner2", got[4*W+6], tx(255));
    chk("t2_max_out", got[3*W+7], 0);
    run_frame(3, 0, -1);
    chk("t3_min_centre", got[3*W+5], 0);
    run_frame(0, 0, -1);
    chk("t3_pass_centre", got[3*W+5], tx(255));
    chk("t3_pass_nbr", got[3*W+4], 0);

    foreach (img[i]) img[i] = 8'($urandom);
    run_frame(1, 0, -1);
    ref_got = got;
    run_frame(1, 1, -1);
    diffs = 0;
    foreach (got[i]) if (got[i] !== ref_got[i]) diffs++;
    chk("stall_identical", diffs, 0);
    run_frame(2, 1, -1);
    run_frame(3, 1, -1);

    run_frame(1, 1, 50);
    foreach (img[i]) img[i] = 8'($urandom);
    run_frame(3, 0, -1);
    run_frame(int'($urandom_range(3)), 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
